// File: rtl/noc_route_pkg.sv
// noc_route_pkg: shared types, sizing limits and the route function
// used by the NoC routing decoder node.
package noc_route_pkg;

  localparam int DEF_NOUT = 2;
  localparam int DEF_AW   = 4;
  localparam int MAX_NOUT = 8;
  localparam int MAX_AW   = 16;

  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [MAX_AW-1:0] mask;
  } route_entry_t;

  typedef route_entry_t [MAX_NOUT-1:0] route_tbl_t;

  // Power-on table contents: entry k matches address k exactly.
  // In tree mode entry 0 starts with an empty mask (test the MSB).
  function automatic route_entry_t route_default(
    input int   k,
    input int   aw,
    input logic tree
  );
    route_entry_t      e;
    logic [MAX_AW-1:0] am;
    am     = MAX_AW'((32'd1 << aw) - 32'd1);
    e.addr = MAX_AW'(k) & am;
    e.mask = (tree && k == 0) ? '0 : am;
    return e;
  endfunction

  // Leaf: lowest matching entry, else the last port.
  // Tree: mask[0] popcount selects which field bit steers.
  function automatic logic [2:0] route_pick(
    input logic [MAX_AW-1:0] f,
    input route_tbl_t        tbl,
    input int                nout,
    input int                aw,
    input logic              tree
  );
    logic [2:0] p;
    logic       hit;
    int         n;
    logic [3:0] bi;
    p   = 3'(nout - 1);
    hit = 1'b0;
    n   = 0;
    bi  = '0;
    if (tree) begin
      for (int i = 0; i < MAX_AW; i++) begin
        if (i < aw && tbl[0].mask[i[3:0]]) n++;
      end
      if (n >= aw) begin
        p = 3'd1;
      end else begin
        bi = 4'(aw - 1 - n);
        p  = {2'b00, f[bi]};
      end
    end else begin
      for (int k = 0; k < MAX_NOUT; k++) begin
        if (!hit && k < nout &&
            (f & tbl[k[2:0]].mask) == tbl[k[2:0]].addr) begin
          hit = 1'b1;
          p   = 3'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/noc_route_decoder_slot.sv
// noc_route_slot: one-entry valid/ready holding register.
// Ports: CLK, RESET (async, active-high), i_load/i_data write side,
//        o_valid/o_data/i_ready read side.
// The owner only loads when the slot is empty or draining this edge.
module noc_route_slot #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/noc_route_decoder.sv
// noc_route_decoder: routing node; S0 input register, route lookup,
// S1 per-port output slots plus a select slot committed together.
// Ports: CLK, RESET (async, active-high); in_* flit input; cfg_* table
//   write; out_* NOUT flit channels; sel_* chosen-port side band.
// Optional ROUTE_STATS_EN adds stat_cnt, 16-bit per-port counters.
module noc_route_decoder
  import noc_route_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = DEF_AW,
  parameter int ADDR_LSB  = 5,
  parameter int NOUT      = DEF_NOUT,
  parameter int TREE_MODE = 0,
  parameter int SW        = $clog2(NOUT)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_idx,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [AW-1:0]     cfg_mask,
  output logic [NOUT*DW-1:0] out_data,
  output logic [NOUT-1:0]   out_valid,
  input  logic [NOUT-1:0]   out_ready,
  output logic [SW-1:0]     sel_data,
  output logic              sel_valid,
  input  logic              sel_ready
`ifdef ROUTE_STATS_EN
  ,
  output logic [NOUT*16-1:0] stat_cnt
`endif
);

  logic              r_s0_valid;
  logic [DW-1:0]     r_s0_data;
  route_tbl_t        w_tbl;
  logic [MAX_AW-1:0] w_field;
  logic [2:0]        w_pick;
  logic [SW-1:0]     w_port;
  logic              w_port_free;
  logic              w_sel_free;
  logic              w_s0_fire;
  logic              w_in_fire;
  logic [NOUT-1:0]   w_load;

  // Route table; unused upper entries read as zero.
  for (genvar k = 0; k < MAX_NOUT; k++) begin : g_tbl
    if (k < NOUT) begin : g_used
      route_entry_t r_ent;
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          r_ent <= route_default(k, AW, TREE_MODE != 0);
        end else if (cfg_we && cfg_idx == SW'(k)) begin
          r_ent <= '{addr: MAX_AW'(cfg_addr),
                     mask: MAX_AW'(cfg_mask)};
        end
      end
      assign w_tbl[k] = r_ent;
    end else begin : g_unused
      assign w_tbl[k] = '0;
    end
  end

  assign w_field = MAX_AW'(r_s0_data[ADDR_LSB +: AW]);
  assign w_pick  = route_pick(w_field, w_tbl, NOUT, AW,
                              TREE_MODE != 0);
  assign w_port  = w_pick[SW-1:0];

  // Flit and select move as one: both targets must have room.
  assign w_port_free = !out_valid[w_port] || out_ready[w_port];
  assign w_sel_free  = !sel_valid || sel_ready;
  assign w_s0_fire   = r_s0_valid && w_port_free && w_sel_free;

  // Held low for the whole reset window, not just after an edge.
  assign in_ready  = !RESET && (!r_s0_valid || w_s0_fire);
  assign w_in_fire = in_valid && in_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s0_valid <= 1'b0;
      r_s0_data  <= '0;
    end else if (w_in_fire) begin
      r_s0_valid <= 1'b1;
      r_s0_data  <= in_data;
    end else if (w_s0_fire) begin
      r_s0_valid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NOUT; k++) begin : g_out
    assign w_load[k] = w_s0_fire && (w_port == SW'(k));
    noc_route_slot #(.W(DW)) u_slot (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_load  (w_load[k]),
      .i_data  (r_s0_data),
      .o_data  (out_data[k*DW +: DW]),
      .o_valid (out_valid[k]),
      .i_ready (out_ready[k])
    );
  end

  noc_route_slot #(.W(SW)) u_sel (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_load  (w_s0_fire),
    .i_data  (w_port),
    .o_data  (sel_data),
    .o_valid (sel_valid),
    .i_ready (sel_ready)
  );

`ifdef ROUTE_STATS_EN
  for (genvar k = 0; k < NOUT; k++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_cnt <= '0;
      end else if (out_valid[k] && out_ready[k]) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_cnt[k*16 +: 16] = r_cnt;
  end
`endif

endmodule
